// File: rtl/arb_pkg.sv
// Shared definitions for the one-hot round-robin arbiter: requester count,
// index code width, pointer width and the arbiter state type.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/one_hot_to_bcd.sv
// Converts an 8-bit one-hot vector to its 4-bit BCD index (0..7).
// An all-zero input yields 0; bit 3 of the result is always 0.
module one_hot_to_bcd
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot_i,
  output logic [BCD_W-1:0] bcd_o
);

  // OR together the indices of all set bits; for a one-hot input this is the index.
  always_comb begin
    bcd_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (onehot_i[i]) begin
        bcd_o = bcd_o | BCD_W'(i);
      end
    end
  end

endmodule

// File: rtl/one_hot_rr_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one resource. Issues a
// registered one-hot grant and its BCD index; a grant persists while the
// owner holds its request and is revoked after MAX_HOLD cycles when other
// requesters are waiting. At least one idle cycle separates grants.
module one_hot_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [BCD_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [BCD_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               preempt_q, preempt_d;

  logic [N_REQ-1:0]   req_rot;
  logic [N_REQ-1:0]   sel_rot;
  logic [N_REQ-1:0]   pick;
  logic [PTR_W-1:0]   owner_nxt;
  logic               owner_req;
  logic               others_req;

  // Round-robin pick: rotate so ptr is bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    req_rot = '0;
    pick    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[PTR_W'(i) + ptr_q];
    end
    sel_rot = req_rot & (~req_rot + N_REQ'(1));
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pick[i] = sel_rot[PTR_W'(i) - ptr_q];
    end
  end

  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign owner_nxt  = gnt_idx_q[PTR_W-1:0] + PTR_W'(1);

  // Next-state logic: grant from IDLE, release or preempt from GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        gnt_d  = '0;
        if (en && (|req)) begin
          gnt_d   = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          gnt_d   = '0;
          ptr_d   = owner_nxt;
          hold_d  = '0;
          state_d = ST_IDLE;
        end else if ((hold_q >= HOLD_LAST) && others_req) begin
          // hold_q may already be saturated past HOLD_LAST when a competitor
          // shows up late; that must still preempt.
          gnt_d     = '0;
          ptr_d     = owner_nxt;
          hold_d    = '0;
          preempt_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  one_hot_to_bcd u_enc (
    .onehot_i (gnt_d),
    .bcd_o    (gnt_idx_d)
  );

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign preempt   = preempt_q;

endmodule
